// File: rtl/dsc_mul_sched_pkg.sv
// Shared types for the serial-multiplier operation scheduler.
package dsc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/dsc_mul_sched_if.sv
// Job-in / result-out handshake bundle between host logic and the scheduler.
interface dsc_mul_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2,
  parameter int CNT_WIDTH  = 16
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]             out_cycles;
  logic                             out_truncated;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cycles, out_truncated
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cycles, out_truncated
  );
endinterface

// File: rtl/dsc_mul_sched_counter.sv
// Up-counter with async reset, synchronous clear and enable; wraps on overflow.
module counter #(
  parameter int WIDTH  = 16,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  count <= '0;
    else if (rst) count <= '0;
    else if (en)  count <= count + WIDTH'(STRIDE);
  end

endmodule

// File: rtl/dsc_mul_sched.sv
// Sequences one serial multiplier: clear, run until done or budget, hold result.
module dsc_mul_sched
  import dsc_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  dsc_mul_sched_if.slave                   host,
  input  logic [CNT_WIDTH-1:0]             budget,
  output logic                             mul_rst,
  output logic                             mul_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_data,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_out,
  input  logic                             mul_done,
  output logic [CNT_WIDTH-1:0]             jobs_done,
  output logic                             busy
);

  localparam int W = NUM_INPUTS * DATA_WIDTH;

  sched_state_t         state, state_nxt;
  logic [CNT_WIDTH-1:0] cycles, cycles_nxt, budget_q;
  logic                 accept, run_exit;
  logic                 in_ready_nxt, mul_rst_nxt, mul_en_nxt, out_valid_nxt, busy_nxt;

  assign accept     = (state == IDLE) && host.in_valid;
  // cycles_nxt is what the run counter will hold after this RUN cycle,
  // so budget and saturation compare against the post-increment count.
  assign cycles_nxt = cycles + CNT_WIDTH'(1);
  assign run_exit   = (state == RUN) &&
                      (mul_done || ((budget_q != '0) && (cycles_nxt == budget_q)) ||
                       (cycles_nxt == '1));

  counter #(.WIDTH(CNT_WIDTH), .STRIDE(1)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .rst   (state inside {IDLE, CLEAR}),
    .en    (state == RUN),
    .count (cycles)
  );

  counter #(.WIDTH(CNT_WIDTH), .STRIDE(1)) u_job_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .rst   (1'b0),
    .en    ((state == HOLD) && host.out_ready),
    .count (jobs_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = CLEAR;
      CLEAR:                       state_nxt = RUN;
      RUN:     if (run_exit)       state_nxt = HOLD;
      HOLD:    if (host.out_ready) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
    // outputs are decoded from the next state so they leave flops
    in_ready_nxt  = (state_nxt == IDLE);
    mul_rst_nxt   = (state_nxt == IDLE) || (state_nxt == CLEAR);
    mul_en_nxt    = (state_nxt == RUN);
    out_valid_nxt = (state_nxt == HOLD);
    busy_nxt      = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      host.in_ready  <= 1'b1;
      mul_rst        <= 1'b1;
      mul_en         <= 1'b0;
      host.out_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      host.in_ready  <= in_ready_nxt;
      mul_rst        <= mul_rst_nxt;
      mul_en         <= mul_en_nxt;
      host.out_valid <= out_valid_nxt;
      busy           <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_data <= '0;
      budget_q <= '0;
    end else if (accept) begin
      mul_data <= host.in_data;
      budget_q <= budget;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host.out_data      <= '0;
      host.out_cycles    <= '0;
      host.out_truncated <= 1'b0;
    end else if (run_exit) begin
      host.out_data      <= W'(mul_out);
      host.out_cycles    <= cycles_nxt;
      host.out_truncated <= !mul_done;
    end
  end

endmodule
